tlp_recv: RTL



---
 rtl/tlp_recv.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/tlp_recv.sv
// tlp_recv: parses the 64-bit Avalon-ST PCIe RX stream into tlp_xcvr_pkg::Action entries queued in a small FIFO.
// Optional build macro TLP_RECV_STRICT_EN rejects MRd32/MWr32 with length!=1 or firstBE!=4'hF.
package tlp_xcvr_pkg;
  localparam int unsigned CHAN_W = 4;
  typedef logic [CHAN_W-1:0] Channel;
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_WRITE = 2'd1,
    ACT_READ  = 2'd2,
    ACT_ERROR = 2'd3
  } ActKind;
  typedef struct packed {
    ActKind      kind;
    logic [15:0] reqId;
    logic [7:0]  tag;
    Channel      chan;
    logic [31:0] data;
    logic [7:0]  code;
  } Action;
endpackage

module tlp_recv
  import tlp_xcvr_pkg::*;
#(
  parameter int unsigned ACT_FIFO_DEPTH = 4,
  parameter int unsigned CHAN_LSB       = 3
) (
  input  logic        pcieClk_in,
  input  logic        pcieRstN_in,
  input  logic [63:0] rxData_in,
  input  logic        rxValid_in,
  output logic        rxReady_out,
  input  logic        rxSOP_in,
  input  logic        rxEOP_in,
  output Action       actData_out,
  output logic        actValid_out,
  input  logic        actReady_in
);

  localparam int unsigned PW = (ACT_FIFO_DEPTH > 1) ? $clog2(ACT_FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(ACT_FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR1, S_DATA, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  fmt_q;
  logic [9:0]  len_q;
  logic [15:0] reqId_q;
  logic [7:0]  tag_q;
  logic [3:0]  be_q;
  Channel      chan_q;

  Action       mem_q [ACT_FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  logic        full, beat, push, pop, latch, latchChan;
  Action       pushAct;
  logic [31:0] addr;
  Channel      chanW;
  logic        isMrd, isMwr, strictBad;
  logic [7:0]  strictCode;

  assign full         = (count_q == DEPTH_C);
  assign actValid_out = (count_q != '0);
  assign actData_out  = actValid_out ? mem_q[rd_q] : '0;
  assign pop          = actValid_out && actReady_in;
  // Drained beats never push, except an SOP which pushes the abandon error.
  assign rxReady_out  = pcieRstN_in && (!full || (state_q == S_DRAIN && !rxSOP_in));
  assign beat         = rxValid_in && rxReady_out;

  assign addr  = rxData_in[31:0];
  assign chanW = addr[CHAN_LSB +: CHAN_W];
  assign isMrd = (fmt_q == 8'h00);
  assign isMwr = (fmt_q == 8'h40);

`ifdef TLP_RECV_STRICT_EN
  assign strictBad  = (isMrd || isMwr) && ((len_q != 10'd1) || (be_q != 4'hF));
  assign strictCode = (len_q != 10'd1) ? 8'hFE : 8'hFD;
`else
  logic unusedHdr;
  assign unusedHdr  = ^{len_q, be_q};
  assign strictBad  = 1'b0;
  assign strictCode = '0;
`endif

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    pushAct   = '0;
    latch     = 1'b0;
    latchChan = 1'b0;
    if (beat) begin
      if (rxSOP_in) begin
        if (state_q != S_IDLE) begin
          push         = 1'b1;
          pushAct.kind = ACT_ERROR;
          pushAct.code = 8'hFF;
        end
        latch   = 1'b1;
        state_d = S_HDR1;
      end else begin
        case (state_q)
          S_HDR1: begin
            latchChan = 1'b1;
            state_d   = rxEOP_in ? S_IDLE : S_DRAIN;
            if (strictBad) begin
              push         = 1'b1;
              pushAct.kind = ACT_ERROR;
              pushAct.code = strictCode;
            end else if (isMrd) begin
              push          = 1'b1;
              pushAct.kind  = ACT_READ;
              pushAct.reqId = reqId_q;
              pushAct.tag   = tag_q;
              pushAct.chan  = chanW;
            end else if (isMwr && addr[2]) begin
              push         = 1'b1;
              pushAct.kind = ACT_WRITE;
              pushAct.chan = chanW;
              pushAct.data = rxData_in[63:32];
            end else if (isMwr) begin
              state_d = S_DATA;
            end else begin
              push         = 1'b1;
              pushAct.kind = ACT_ERROR;
              pushAct.code = fmt_q;
            end
          end
          S_DATA: begin
            push         = 1'b1;
            pushAct.kind = ACT_WRITE;
            pushAct.chan = chan_q;
            pushAct.data = rxData_in[31:0];
            state_d      = rxEOP_in ? S_IDLE : S_DRAIN;
          end
          S_DRAIN: begin
            if (rxEOP_in) state_d = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state_q <= S_IDLE;
      fmt_q   <= '0;
      len_q   <= '0;
      reqId_q <= '0;
      tag_q   <= '0;
      be_q    <= '0;
      chan_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        fmt_q   <= rxData_in[31:24];
        len_q   <= rxData_in[9:0];
        reqId_q <= rxData_in[63:48];
        tag_q   <= rxData_in[47:40];
        be_q    <= rxData_in[35:32];
      end
      if (latchChan) chan_q <= chanW;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (push) mem_q[wr_q] <= pushAct;
  end

endmodule
